decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- ID stage of the 5-stage RV32I pipeline, sitting between the IF/ID register and EX.
- Decodes the instruction, drives the register-file read addresses and consumes the asynchronous read data.
- Applies the same-cycle writeback bypass, generates the immediate, detects load-use hazards, and registers everything into the ID/EX pipeline register.
- Latency: 1 cycle from IF/ID to ID/EX.

Parameters:
XLEN, 32, datapath width
RA_W, 5, register address width

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
if_valid  in  1  IF/ID holds a real instruction
if_instr  in  XLEN  instruction word
if_pc  in  XLEN  instruction PC
flush  in  1  branch/jump resolved taken; ID instruction is wrong-path
rf_rs1  out  RA_W  register-file read address 1 (= if_instr[19:15])
rf_rs2  out  RA_W  register-file read address 2 (= if_instr[24:20])
rf_rd1  in  XLEN  register-file read data 1
rf_rd2  in  XLEN  register-file read data 2
wb_we  in  1  writeback write enable (same net as register-file write enable)
wb_wa  in  RA_W  writeback address
wb_wd  in  XLEN  writeback data
stall_out  out  1  hold PC and IF/ID this cycle (combinational)
ex_valid  out  1  ID/EX holds a real instruction
ex_pc  out  XLEN  registered PC
ex_rs1_val  out  XLEN  registered operand 1
ex_rs2_val  out  XLEN  registered operand 2
ex_imm  out  XLEN  registered sign-extended immediate
ex_rs1  out  RA_W  registered source 1 address
ex_rs2  out  RA_W  registered source 2 address
ex_rd  out  RA_W  registered destination address
ex_funct3  out  3  registered funct3
ex_funct7b5  out  1  registered instr[30]
ex_reg_write  out  1  writes rd
ex_mem_read  out  1  load
ex_mem_write  out  1  store
ex_branch  out  1  conditional branch
ex_jump  out  1  JAL/JALR
ex_alu_src  out  1  ALU operand B = imm
ex_illegal  out  1  opcode not in RV32I base set

Behaviour:
- Reset: all ex_* outputs = 0. stall_out = 0 while rst is high. Reset has priority over flush and stall.
- Register file writes on the clock edge, so the register-file read data is stale in the write cycle. Bypass therefore applies to each operand n:
  - rsN == 0 -> value 0.
  - else if wb_we && wb_wa == rsN -> value wb_wd.
  - else -> value rf_rdN.
- Operand usage:
  - uses_rs1: opcodes R, I-ALU, LOAD, STORE, BRANCH, JALR.
  - uses_rs2: opcodes R, STORE, BRANCH.
- Load-use hazard = if_valid && ex_valid && ex_mem_read && ex_rd != 0 && ((uses_rs1 && ex_rd == rs1) || (uses_rs2 && ex_rd == rs2)).
- stall_out = hazard && !flush && !rst.
- Register update at each posedge, first matching case wins:
  1. rst -> all ex_* = 0.
  2. flush, or !if_valid, or hazard -> bubble: ex_valid and all control bits (ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_alu_src, ex_illegal) = 0; datapath fields don't-care, driven 0.
  3. otherwise -> capture the decoded instruction with ex_valid = 1.
- A stalled instruction stays in IF/ID and is re-decoded next cycle. The load has then moved on, so the hazard clears after exactly one bubble.
- Immediate formats (sign bit instr[31]):
  - I: opcodes 0010011, 0000011, 1100111.
  - S: 0100011.
  - B: 1100011 (bit 0 = 0).
  - U: 0110111, 0010111 (low 12 bits = 0).
  - J: 1101111 (bit 0 = 0).
  - R (0110011): 0.
- Control per opcode:
  - reg_write: R, I-ALU, LOAD, LUI, AUIPC, JAL, JALR.
  - alu_src: I-ALU, LOAD, STORE, LUI, AUIPC, JALR.
  - ex_rd forced to 0 for STORE and BRANCH.
- Unknown opcode: ex_valid = 1, ex_illegal = 1, all other control bits 0, ex_rd = 0.

Decomposition:
- Package riscv_pkg:
  - opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC);
  - XLEN and RA_W defaults;
  - immediate-format enum (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE).
- One sub-module, imm_gen: purely combinational, takes instr and format, returns imm.

Test Plan:
- Reset: hold rst 2 cycles with if_valid = 1 -> all ex_* = 0, stall_out = 0.
- Decode: addi x5,x1,-3 (0xFFD08293) with rf_rd1 = 10 -> next cycle ex_rs1_val = 10, ex_imm = 0xFFFFFFFD, ex_rd = 5, ex_reg_write = 1, ex_alu_src = 1.
- WB bypass: rf_rd1 = 7, wb_we = 1, wb_wa = 1, wb_wd = 99, instr reads x1 -> ex_rs1_val = 99. Repeat with wb_wa = 0 and instr reading x0 -> ex_rs1_val = 0.
- Load-use: lw x3,0(x2) followed by add x4,x3,x3 -> stall_out = 1 for one cycle, ex_valid = 0 (bubble); next cycle add is captured and stall_out = 0.
- Flush with hazard: same load-use pair with flush = 1 -> stall_out = 0, bubble registered.
- Immediates: beq offset -8 -> ex_imm = 0xFFFFFFF8. jal offset +2048 -> 0x00000800. lui 0x12345 -> 0x12345000. Opcode 0x7F -> ex_illegal = 1, ex_reg_write = 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcode values, default datapath widths,
// immediate format selector and the per-opcode control bundle.
package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int RA_W_DEFAULT = 5;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_fmt_e;

  typedef struct packed {
    logic     reg_write;
    logic     mem_read;
    logic     mem_write;
    logic     branch;
    logic     jump;
    logic     alu_src;
    logic     illegal;
    logic     uses_rs1;
    logic     uses_rs2;
    imm_fmt_e fmt;
  } ctrl_t;

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: sign-extends the immediate field of an RV32I
// instruction according to the selected format. Purely combinational.
// Ports:
//   instr - instruction bits [31:7] (opcode bits carry no immediate data)
//   fmt   - immediate format selected by the decoder
//   imm   - sign-extended immediate, 0 for formats without one
module imm_gen
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [31:7]     instr,
  input  imm_fmt_e        fmt,
  output logic [XLEN-1:0] imm
);

  always_comb begin
    imm = '0;
    case (fmt)
      IMM_I: imm = {{(XLEN-11){instr[31]}}, instr[30:20]};
      IMM_S: imm = {{(XLEN-11){instr[31]}}, instr[30:25], instr[11:7]};
      IMM_B: imm = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U: imm = {{(XLEN-31){instr[31]}}, instr[30:12], 12'b0};
      IMM_J: imm = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// ID stage of the 5-stage RV32I pipeline. Decodes the IF/ID instruction,
// reads the register file (with same-cycle writeback bypass), builds the
// immediate, detects load-use hazards and registers the result into ID/EX.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   if_valid, if_instr, if_pc      - IF/ID register contents
//   flush                          - current ID instruction is wrong-path
//   rf_rs1, rf_rs2, rf_rd1, rf_rd2 - register-file read ports (async data)
//   wb_we, wb_wa, wb_wd            - writeback port, used for bypass
//   stall_out                      - hold PC and IF/ID (combinational)
//   ex_*                           - ID/EX pipeline register outputs
module decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int RA_W = RA_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_instr,
  input  logic [XLEN-1:0] if_pc,
  input  logic            flush,
  output logic [RA_W-1:0] rf_rs1,
  output logic [RA_W-1:0] rf_rs2,
  input  logic [XLEN-1:0] rf_rd1,
  input  logic [XLEN-1:0] rf_rd2,
  input  logic            wb_we,
  input  logic [RA_W-1:0] wb_wa,
  input  logic [XLEN-1:0] wb_wd,
  output logic            stall_out,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1_val,
  output logic [XLEN-1:0] ex_rs2_val,
  output logic [XLEN-1:0] ex_imm,
  output logic [RA_W-1:0] ex_rs1,
  output logic [RA_W-1:0] ex_rs2,
  output logic [RA_W-1:0] ex_rd,
  output logic [2:0]      ex_funct3,
  output logic            ex_funct7b5,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_branch,
  output logic            ex_jump,
  output logic            ex_alu_src,
  output logic            ex_illegal
);

  logic [6:0]      opcode;
  logic [RA_W-1:0] rs1, rs2, rd_field;
  ctrl_t           ctrl;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            hazard;

  assign opcode   = if_instr[6:0];
  assign rd_field = if_instr[7 +: RA_W];
  assign rs1      = if_instr[15 +: RA_W];
  assign rs2      = if_instr[20 +: RA_W];
  assign rf_rs1   = rs1;
  assign rf_rs2   = rs2;

  always_comb begin
    ctrl     = '0;
    ctrl.fmt = IMM_NONE;
    case (opcode)
      OP_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.uses_rs1  = 1'b1;
        ctrl.uses_rs2  = 1'b1;
      end
      OP_IMM: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.uses_rs1  = 1'b1;
        ctrl.fmt       = IMM_I;
      end
      OP_LOAD: begin
        ctrl.reg_write = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.uses_rs1  = 1'b1;
        ctrl.fmt       = IMM_I;
      end
      OP_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.uses_rs1  = 1'b1;
        ctrl.uses_rs2  = 1'b1;
        ctrl.fmt       = IMM_S;
      end
      OP_BRANCH: begin
        ctrl.branch   = 1'b1;
        ctrl.uses_rs1 = 1'b1;
        ctrl.uses_rs2 = 1'b1;
        ctrl.fmt      = IMM_B;
      end
      OP_JAL: begin
        ctrl.reg_write = 1'b1;
        ctrl.jump      = 1'b1;
        ctrl.fmt       = IMM_J;
      end
      OP_JALR: begin
        ctrl.reg_write = 1'b1;
        ctrl.jump      = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.uses_rs1  = 1'b1;
        ctrl.fmt       = IMM_I;
      end
      OP_LUI, OP_AUIPC: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.fmt       = IMM_U;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (if_instr[31:7]),
    .fmt   (ctrl.fmt),
    .imm   (imm)
  );

  // The register file writes on the same edge that ID/EX captures, so its
  // read data is stale during a writeback cycle; forward wb_wd instead.
  always_comb begin
    if (rs1 == '0)                      rs1_val = '0;
    else if (wb_we && (wb_wa == rs1))   rs1_val = wb_wd;
    else                                rs1_val = rf_rd1;
    if (rs2 == '0)                      rs2_val = '0;
    else if (wb_we && (wb_wa == rs2))   rs2_val = wb_wd;
    else                                rs2_val = rf_rd2;
  end

  logic            ex_valid_q, ex_valid_d;
  logic [XLEN-1:0] ex_pc_q, ex_pc_d;
  logic [XLEN-1:0] ex_rs1_val_q, ex_rs1_val_d;
  logic [XLEN-1:0] ex_rs2_val_q, ex_rs2_val_d;
  logic [XLEN-1:0] ex_imm_q, ex_imm_d;
  logic [RA_W-1:0] ex_rs1_q, ex_rs1_d;
  logic [RA_W-1:0] ex_rs2_q, ex_rs2_d;
  logic [RA_W-1:0] ex_rd_q, ex_rd_d;
  logic [2:0]      ex_funct3_q, ex_funct3_d;
  logic            ex_funct7b5_q, ex_funct7b5_d;
  logic [6:0]      ex_ctrl_q, ex_ctrl_d;

  // Only a load sitting in EX can create a hazard that forwarding from a
  // later stage cannot cover. One bubble is enough: the load moves on.
  assign hazard = if_valid && ex_valid_q && ex_ctrl_q[5] && (ex_rd_q != '0) &&
                  ((ctrl.uses_rs1 && (ex_rd_q == rs1)) ||
                   (ctrl.uses_rs2 && (ex_rd_q == rs2)));

  assign stall_out = hazard && !flush && !rst;

  always_comb begin
    ex_valid_d    = 1'b0;
    ex_pc_d       = '0;
    ex_rs1_val_d  = '0;
    ex_rs2_val_d  = '0;
    ex_imm_d      = '0;
    ex_rs1_d      = '0;
    ex_rs2_d      = '0;
    ex_rd_d       = '0;
    ex_funct3_d   = '0;
    ex_funct7b5_d = 1'b0;
    ex_ctrl_d     = '0;
    if (!(flush || !if_valid || hazard)) begin
      ex_valid_d    = 1'b1;
      ex_pc_d       = if_pc;
      ex_rs1_val_d  = rs1_val;
      ex_rs2_val_d  = rs2_val;
      ex_imm_d      = imm;
      ex_rs1_d      = rs1;
      ex_rs2_d      = rs2;
      // Stores, branches and illegal opcodes never write rd.
      ex_rd_d       = ctrl.reg_write ? rd_field : '0;
      ex_funct3_d   = if_instr[14:12];
      ex_funct7b5_d = if_instr[30];
      ex_ctrl_d     = {ctrl.reg_write, ctrl.mem_read, ctrl.mem_write,
                       ctrl.branch, ctrl.jump, ctrl.alu_src, ctrl.illegal};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q    <= 1'b0;
      ex_pc_q       <= '0;
      ex_rs1_val_q  <= '0;
      ex_rs2_val_q  <= '0;
      ex_imm_q      <= '0;
      ex_rs1_q      <= '0;
      ex_rs2_q      <= '0;
      ex_rd_q       <= '0;
      ex_funct3_q   <= '0;
      ex_funct7b5_q <= 1'b0;
      ex_ctrl_q     <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_pc_q       <= ex_pc_d;
      ex_rs1_val_q  <= ex_rs1_val_d;
      ex_rs2_val_q  <= ex_rs2_val_d;
      ex_imm_q      <= ex_imm_d;
      ex_rs1_q      <= ex_rs1_d;
      ex_rs2_q      <= ex_rs2_d;
      ex_rd_q       <= ex_rd_d;
      ex_funct3_q   <= ex_funct3_d;
      ex_funct7b5_q <= ex_funct7b5_d;
      ex_ctrl_q     <= ex_ctrl_d;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_pc        = ex_pc_q;
  assign ex_rs1_val   = ex_rs1_val_q;
  assign ex_rs2_val   = ex_rs2_val_q;
  assign ex_imm       = ex_imm_q;
  assign ex_rs1       = ex_rs1_q;
  assign ex_rs2       = ex_rs2_q;
  assign ex_rd        = ex_rd_q;
  assign ex_funct3    = ex_funct3_q;
  assign ex_funct7b5  = ex_funct7b5_q;
  assign ex_reg_write = ex_ctrl_q[6];
  assign ex_mem_read  = ex_ctrl_q[5];
  assign ex_mem_write = ex_ctrl_q[4];
  assign ex_branch    = ex_ctrl_q[3];
  assign ex_jump      = ex_ctrl_q[2];
  assign ex_alu_src   = ex_ctrl_q[1];
  assign ex_illegal   = ex_ctrl_q[0];

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_instr, if_pc;
  logic        flush;
  logic [4:0]  rf_rs1, rf_rs2;
  logic [31:0] rf_rd1, rf_rd2;
  logic        wb_we;
  logic [4:0]  wb_wa;
  logic [31:0] wb_wd;
  logic        stall_out;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  ex_funct3;
  logic        ex_funct7b5, ex_reg_write, ex_mem_read, ex_mem_write;
  logic        ex_branch, ex_jump, ex_alu_src, ex_illegal;

  decode_stage dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .flush(flush), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
    .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd), .stall_out(stall_out),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
    .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
    .ex_jump(ex_jump), .ex_alu_src(ex_alu_src), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rs1_val, rs2_val, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  funct3;
    logic        f7b5, reg_write, mem_read, mem_write, branch, jump, alu_src, illegal;
  } exp_t;

  exp_t sb[$];
  int tests_run = 0;
  int tests_failed = 0;

  localparam logic [31:0] I_ADDI  = 32'hFFD08293; // addi x5,x1,-3
  localparam logic [31:0] I_ADDI0 = 32'hFFD00293; // addi x5,x0,-3
  localparam logic [31:0] I_LW    = 32'h00012183; // lw x3,0(x2)
  localparam logic [31:0] I_ADD   = 32'h00318233; // add x4,x3,x3
  localparam logic [31:0] I_BEQ   = 32'hFE000CE3; // beq x0,x0,-8
  localparam logic [31:0] I_JAL   = 32'h001000EF; // jal x1,+2048
  localparam logic [31:0] I_LUI   = 32'h123453B7; // lui x7,0x12345
  localparam logic [31:0] I_SW    = 32'hFE512E23; // sw x5,-4(x2)
  localparam logic [31:0] I_BAD   = 32'h00000FFF; // opcode 0x7F

  function automatic exp_t observe();
    exp_t o;
    o.valid = ex_valid; o.pc = ex_pc; o.rs1_val = ex_rs1_val; o.rs2_val = ex_rs2_val;
    o.imm = ex_imm; o.rs1 = ex_rs1; o.rs2 = ex_rs2; o.rd = ex_rd; o.funct3 = ex_funct3;
    o.f7b5 = ex_funct7b5; o.reg_write = ex_reg_write; o.mem_read = ex_mem_read;
    o.mem_write = ex_mem_write; o.branch = ex_branch; o.jump = ex_jump;
    o.alu_src = ex_alu_src; o.illegal = ex_illegal;
    return o;
  endfunction

  // Advance one cycle, sample away from the edge and pop the expected entry.
  task automatic advance(output exp_t e, output exp_t o);
    @(posedge clk);
    #1;
    o = observe();
    if (sb.size() == 0) begin
      e = '0;
      tests_run++;
      tests_failed++;
      $display("FAIL scoreboard_empty: no expected entry at t=%0t", $time);
    end else begin
      e = sb.pop_front();
    end
  endtask

  function automatic exp_t exp_lw(input logic [31:0] pc, input logic [31:0] rd1);
    exp_t e = '0;
    e.valid = 1; e.pc = pc; e.rs1_val = rd1; e.rs1 = 5'd2; e.rd = 5'd3;
    e.funct3 = 3'd2; e.reg_write = 1; e.mem_read = 1; e.alu_src = 1;
    return e;
  endfunction

  function automatic exp_t exp_add(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b);
    exp_t e = '0;
    e.valid = 1; e.pc = pc; e.rs1_val = a; e.rs2_val = b; e.rs1 = 5'd3; e.rs2 = 5'd3;
    e.rd = 5'd4; e.reg_write = 1;
    return e;
  endfunction

  task automatic test_reset();
    exp_t e, o;
    rst = 1; if_valid = 1; if_instr = I_ADDI; if_pc = 32'h100; flush = 0;
    rf_rd1 = 32'd10; rf_rd2 = 32'h55; wb_we = 0; wb_wa = 0; wb_wd = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      tests_run++;
      if (stall_out !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_stall: got %b expected 0", stall_out);
      end
      sb.push_back('0);
      advance(e, o);
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL reset_ex: got %h expected %h", o, e);
      end
    end
    rst = 0;
  endtask

  task automatic test_decode();
    exp_t e, o;
    if_instr = I_ADDI; if_pc = 32'h100; rf_rd1 = 32'd10; rf_rd2 = 32'h55; wb_we = 0;
    e = '0;
    e.valid = 1; e.pc = 32'h100; e.rs1_val = 32'd10; e.rs2_val = 32'h55;
    e.imm = 32'hFFFFFFFD; e.rs1 = 5'd1; e.rs2 = 5'd29; e.rd = 5'd5; e.f7b5 = 1;
    e.reg_write = 1; e.alu_src = 1;
    sb.push_back(e);
    advance(e, o);
    tests_run++;
    if (o !== e) begin
      tests_failed++;
      $display("FAIL decode_addi: got %h expected %h", o, e);
    end
  endtask

  task automatic test_bypass();
    exp_t e, o;
    exp_t base;
    base = '0;
    base.valid = 1; base.pc = 32'h104; base.rs2_val = 32'h55; base.imm = 32'hFFFFFFFD;
    base.rs1 = 5'd1; base.rs2 = 5'd29; base.rd = 5'd5; base.f7b5 = 1;
    base.reg_write = 1; base.alu_src = 1;
    // x1 written back this cycle: forwarded value wins over stale read data
    if_instr = I_ADDI; if_pc = 32'h104; rf_rd1 = 32'd7; wb_we = 1; wb_wa = 5'd1; wb_wd = 32'd99;
    e = base; e.rs1_val = 32'd99;
    sb.push_back(e);
    advance(e, o);
    tests_run++;
    if (o !== e) begin
      tests_failed++;
      $display("FAIL bypass_hit: got %h expected %h", o, e);
    end
    // matching address but write enable low: no forwarding
    wb_we = 0;
    e = base; e.rs1_val = 32'd7;
    sb.push_back(e);
    advance(e, o);
    tests_run++;
    if (o !== e) begin
      tests_failed++;
      $display("FAIL bypass_we_low: got %h expected %h", o, e);
    end
    // x0 always reads zero, even with a writeback aimed at x0
    if_instr = I_ADDI0; wb_we = 1; wb_wa = 5'd0; wb_wd = 32'd99;
    e = base; e.rs1 = 5'd0; e.rs1_val = 32'd0;
    sb.push_back(e);
    advance(e, o);
    tests_run++;
    if (o !== e) begin
      tests_failed++;
      $display("FAIL bypass_x0: got %h expected %h", o, e);
    end
    wb_we = 0;
  endtask

  task automatic test_load_use();
    exp_t e, o;
    if_instr = I_LW; if_pc = 32'h200; rf_rd1 = 32'h40; rf_rd2 = 32'h22;
    sb.push_back(exp_lw(32'h200, 32'h40));
    advance(e, o);
    tests_run++;
    if (o !== e) begin
      tests_failed++;
      $display("FAIL lu_load: got %h expected %h", o, e);
    end
    if_instr = I_ADD; if_pc = 32'h204; rf_rd1 = 32'h11; rf_rd2 = 32'h22;
    #1;
    tests_run++;
    if (stall_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL lu_stall: got %b expected 1", stall_out);
    end
    sb.push_back('0);
    advance(e, o);
    tests_run++;
    if (o !== e) begin
      tests_failed++;
      $display("FAIL lu_bubble: got %h expected %h", o, e);
    end
    #1;
    tests_run++;
    if (stall_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL lu_stall_clear: got %b expected 0", stall_out);
    end
    sb.push_back(exp_add(32'h204, 32'h11, 32'h22));
    advance(e, o);
    tests_run++;
    if (o !== e) begin
      tests_failed++;
      $display("FAIL lu_add: got %h expected %h", o, e);
    end
  endtask

  task automatic test_reset_priority();
    exp_t e, o;
    if_instr = I_LW; if_pc = 32'h300; rf_rd1 = 32'h40;
    sb.push_back(exp_lw(32'h300, 32'h40));
    advance(e, o);
    tests_run++;
    if (o !== e) begin
      tests_failed++;
      $display("FAIL rp_load: got %h expected %h", o, e);
    end
    if_instr = I_ADD; if_pc = 32'h304; rst = 1;
    #1;
    tests_run++;
    if (stall_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL rp_stall: got %b expected 0", stall_out);
    end
    sb.push_back('0);
    advance(e, o);
    tests_run++;
    if (o !== e) begin
      tests_failed++;
      $display("FAIL rp_ex: got %h expected %h", o, e);
    end
    rst = 0;
  endtask

  task automatic test_flush();
    exp_t e, o;
    if_instr = I_LW; if_pc = 32'h400; rf_rd1 = 32'h40;
    sb.push_back(exp_lw(32'h400, 32'h40));
    advance(e, o);
    if_instr = I_ADD; if_pc = 32'h404; rf_rd1 = 32'h11; rf_rd2 = 32'h22; flush = 1;
    #1;
    tests_run++;
    if (stall_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_stall: got %b expected 0", stall_out);
    end
    sb.push_back('0);
    advance(e, o);
    tests_run++;
    if (o !== e) begin
      tests_failed++;
      $display("FAIL flush_bubble: got %h expected %h", o, e);
    end
    flush = 0;
    sb.push_back(exp_add(32'h404, 32'h11, 32'h22));
    advance(e, o);
    tests_run++;
    if (o !== e) begin
      tests_failed++;
      $display("FAIL flush_next: got %h expected %h", o, e);
    end
    if_valid = 0;
    sb.push_back('0);
    advance(e, o);
    tests_run++;
    if (o !== e) begin
      tests_failed++;
      $display("FAIL invalid_bubble: got %h expected %h", o, e);
    end
    if_valid = 1;
  endtask

  task automatic test_immediates();
    exp_t e, o;
    rf_rd1 = 32'h11; rf_rd2 = 32'h22; wb_we = 0;
    if_instr = I_BEQ; if_pc = 32'h500;
    e = '0;
    e.valid = 1; e.pc = 32'h500; e.imm = 32'hFFFFFFF8; e.f7b5 = 1; e.branch = 1;
    sb.push_back(e);
    if_instr = I_BEQ;
    advance(e, o);
    tests_run++;
    if (o !== e) begin
      tests_failed++;
      $display("FAIL imm_beq: got %h expected %h", o, e);
    end
    if_instr = I_JAL; if_pc = 32'h504;
    e = '0;
    e.valid = 1; e.pc = 32'h504; e.rs2_val = 32'h22; e.imm = 32'h00000800; e.rs2 = 5'd1;
    e.rd = 5'd1; e.reg_write = 1; e.jump = 1;
    sb.push_back(e);
    advance(e, o);
    tests_run++;
    if (o !== e) begin
      tests_failed++;
      $display("FAIL imm_jal: got %h expected %h", o, e);
    end
    if_instr = I_LUI; if_pc = 32'h508;
    e = '0;
    e.valid = 1; e.pc = 32'h508; e.rs1_val = 32'h11; e.rs2_val = 32'h22;
    e.imm = 32'h12345000; e.rs1 = 5'd8; e.rs2 = 5'd3; e.rd = 5'd7; e.funct3 = 3'd5;
    e.reg_write = 1; e.alu_src = 1;
    sb.push_back(e);
    advance(e, o);
    tests_run++;
    if (o !== e) begin
      tests_failed++;
      $display("FAIL imm_lui: got %h expected %h", o, e);
    end
    if_instr = I_SW; if_pc = 32'h50C;
    e = '0;
    e.valid = 1; e.pc = 32'h50C; e.rs1_val = 32'h11; e.rs2_val = 32'h22;
    e.imm = 32'hFFFFFFFC; e.rs1 = 5'd2; e.rs2 = 5'd5; e.funct3 = 3'd2; e.f7b5 = 1;
    e.mem_write = 1; e.alu_src = 1;
    sb.push_back(e);
    advance(e, o);
    tests_run++;
    if (o !== e) begin
      tests_failed++;
      $display("FAIL imm_sw: got %h expected %h", o, e);
    end
  endtask

  task automatic test_illegal();
    exp_t e, o;
    if_instr = I_BAD; if_pc = 32'h600;
    e = '0;
    e.valid = 1; e.illegal = 1;
    sb.push_back(e);
    advance(e, o);
    tests_run++;
    if ({o.valid, o.illegal, o.rd, o.reg_write, o.mem_read, o.mem_write, o.branch, o.jump, o.alu_src} !==
        {e.valid, e.illegal, e.rd, e.reg_write, e.mem_read, e.mem_write, e.branch, e.jump, e.alu_src}) begin
      tests_failed++;
      $display("FAIL illegal_ctrl: got v=%b ill=%b rd=%0d rw=%b mr=%b mw=%b br=%b j=%b as=%b expected v=1 ill=1 rd=0 others 0",
               o.valid, o.illegal, o.rd, o.reg_write, o.mem_read, o.mem_write, o.branch, o.jump, o.alu_src);
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_bypass();
    test_load_use();
    test_reset_priority();
    test_flush();
    test_immediates();
    test_illegal();
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
